// File: rtl/fifo_write_arbiter_if.sv
// Bundle of requester handshakes, FIFO write port and statistics for fifo_write_arbiter.
// master: the arbiter side. slave: requesters, FIFO and statistics reader.
interface fifo_write_arbiter_if #(
  parameter int unsigned BITS     = 32,
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned CNT_BITS = 16
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]               p_req_valid;
  logic [NUM_REQ-1:0][BITS-1:0]     p_req_data;
  logic [NUM_REQ-1:0]               p_req_last;
  logic [NUM_REQ-1:0]               p_req_ready;
  logic                             p_fifo_write_en;
  logic [BITS-1:0]                  p_fifo_write_data;
  logic                             p_fifo_write_full;
  logic [ID_W-1:0]                  p_grant_id;
  logic                             p_busy;
  logic                             p_stat_clear;
  logic [NUM_REQ-1:0][CNT_BITS-1:0] p_stat_beats;

  modport master (
    input  p_req_valid, p_req_data, p_req_last, p_fifo_write_full, p_stat_clear,
    output p_req_ready, p_fifo_write_en, p_fifo_write_data, p_grant_id, p_busy,
           p_stat_beats
  );

  modport slave (
    output p_req_valid, p_req_data, p_req_last, p_fifo_write_full, p_stat_clear,
    input  p_req_ready, p_fifo_write_en, p_fifo_write_data, p_grant_id, p_busy,
           p_stat_beats
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one async FIFO write port among NUM_REQ requesters.
// A grant lasts until the packet's last beat, MAX_BURST beats, or the owner drops valid;
// every grant costs one idle arbitration cycle. FIFO full stalls the owner in place.
// Optional feature macro: FIFO_WRITE_ARB_STATS_EN (per-requester saturating beat counters).
// Interface parameters BITS/NUM_REQ/CNT_BITS must match the module parameters.
module fifo_write_arbiter #(
  parameter int unsigned BITS      = 32,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_BITS  = 16
) (
  input  logic                  write_clk,
  input  logic                  write_rst_n,
  fifo_write_arbiter_if.master  bus
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  // Reject unsupported configurations at elaboration
  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1) begin : g_bad_params
    $fatal(1, "fifo_write_arbiter: NUM_REQ must be 2..16 and MAX_BURST >= 1");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0]    pick_c;
  logic               pick_found_c;
  logic [NUM_REQ-1:0] ready_c;
  logic               xfer_c;
  logic               release_c;
  logic               write_en_c;
  logic [BITS-1:0]    write_data_c;

  // First valid requester scanning circularly from rr_ptr
  always_comb begin : p_pick
    int unsigned idx;
    pick_c       = '0;
    pick_found_c = 1'b0;
    idx          = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_found_c && bus.p_req_valid[ID_W'(idx)]) begin
        pick_found_c = 1'b1;
        pick_c       = ID_W'(idx);
      end
    end
  end

  // Next-state and port-mux logic
  always_comb begin : p_fsm
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    ready_c      = '0;
    xfer_c       = 1'b0;
    release_c    = 1'b0;
    write_en_c   = 1'b0;
    write_data_c = '0;
    case (state_q)
      IDLE: begin
        if (pick_found_c) begin
          owner_d    = pick_c;
          beat_cnt_d = '0;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        ready_c[owner_q] = !bus.p_fifo_write_full;
        xfer_c           = bus.p_req_valid[owner_q] && !bus.p_fifo_write_full;
        write_en_c       = xfer_c;
        write_data_c     = bus.p_req_data[owner_q];
        if (xfer_c) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        // Owner dropping valid releases even while the FIFO is full
        release_c = !bus.p_req_valid[owner_q] ||
                    (xfer_c && (bus.p_req_last[owner_q] ||
                                beat_cnt_q == CNT_W'(MAX_BURST - 1)));
        if (release_c) begin
          state_d  = IDLE;
          rr_ptr_d = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration state registers
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.p_req_ready       = ready_c;
  assign bus.p_fifo_write_en   = write_en_c;
  assign bus.p_fifo_write_data = write_data_c;
  assign bus.p_grant_id        = owner_q;
  assign bus.p_busy            = (state_q == LOCKED);

`ifdef FIFO_WRITE_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_BITS-1:0] stat_q, stat_d;

  // Saturating per-requester beat counters; clear beats a same-cycle increment
  always_comb begin
    stat_d = stat_q;
    if (bus.p_stat_clear) begin
      stat_d = '0;
    end else if (xfer_c && (stat_q[owner_q] != '1)) begin
      stat_d[owner_q] = stat_q[owner_q] + CNT_BITS'(1);
    end
  end

  // Statistics counter registers
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) stat_q <= '0;
    else              stat_q <= stat_d;
  end

  assign bus.p_stat_beats = stat_q;
`else
  logic unused_stat_clear;
  assign unused_stat_clear = bus.p_stat_clear;
  assign bus.p_stat_beats  = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed cycle traces plus randomized
// traffic compared against a packet-level round-robin reference model.
module tb_fifo_write_arbiter;

  localparam int unsigned BITS      = 32;
  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned CNT_BITS  = 4;
  localparam int          SAT       = (1 << CNT_BITS) - 1;
`ifdef FIFO_WRITE_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef struct packed {
    logic            last;
    logic [BITS-1:0] data;
  } beat_t;

  logic write_clk;
  logic write_rst_n;

  fifo_write_arbiter_if #(.BITS(BITS), .NUM_REQ(NUM_REQ), .CNT_BITS(CNT_BITS)) bus ();

  fifo_write_arbiter #(
    .BITS(BITS), .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .CNT_BITS(CNT_BITS)
  ) dut (
    .write_clk  (write_clk),
    .write_rst_n(write_rst_n),
    .bus        (bus)
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  int n_checks;
  int n_fail;

  beat_t rq [NUM_REQ][$];
  bit    full_plan[$];
  bit    clr_plan[$];
  int    full_pct;
  int    stat_exp [NUM_REQ];

  int              exp_sid[$];
  logic [BITS-1:0] exp_sd[$];
  int              exp_gid[$];
  int              exp_gb[$];
  int              act_sid[$];
  logic [BITS-1:0] act_sd[$];
  int              act_gid[$];
  int              act_gb[$];
  logic            prev_busy;

  logic               tr_wen[$];
  logic               tr_busy[$];
  int                 tr_gid[$];
  logic [BITS-1:0]    tr_data[$];
  logic [NUM_REQ-1:0] tr_ready[$];
  int                 tr_stat1[$];

  function automatic beat_t mk(input logic l, input logic [BITS-1:0] d);
    beat_t b;
    b.last = l;
    b.data = d;
    return b;
  endfunction

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  function automatic int exp_stat(input int i);
    return STATS_ON ? stat_exp[i] : 0;
  endfunction

  // Present queue heads, full and clear for the coming cycle
  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() > 0) begin
        bus.p_req_valid[i] = 1'b1;
        bus.p_req_data[i]  = rq[i][0].data;
        bus.p_req_last[i]  = rq[i][0].last;
      end else begin
        bus.p_req_valid[i] = 1'b0;
        bus.p_req_data[i]  = $urandom;
        bus.p_req_last[i]  = 1'b0;
      end
    end
    if (full_plan.size() > 0) bus.p_fifo_write_full = full_plan.pop_front();
    else bus.p_fifo_write_full = (int'($urandom_range(99)) < full_pct);
    bus.p_stat_clear = (clr_plan.size() > 0) ? clr_plan.pop_front() : 1'b0;
  endtask

  task automatic clear_trace();
    tr_wen.delete(); tr_busy.delete(); tr_gid.delete(); tr_data.delete();
    tr_ready.delete(); tr_stat1.delete();
    act_sid.delete(); act_sd.delete(); act_gid.delete(); act_gb.delete();
  endtask

  // One clock: sample at negedge, check handshake rules, advance queues after posedge
  task automatic step();
    logic [NUM_REQ-1:0] acc;
    logic [NUM_REQ-1:0] exp_acc;
    @(negedge write_clk);
    tr_wen.push_back(bus.p_fifo_write_en);
    tr_busy.push_back(bus.p_busy);
    tr_gid.push_back(int'(bus.p_grant_id));
    tr_data.push_back(bus.p_fifo_write_data);
    tr_ready.push_back(bus.p_req_ready);
    tr_stat1.push_back(int'(bus.p_stat_beats[1]));
    acc = bus.p_req_valid & bus.p_req_ready;
    exp_acc = '0;
    if (bus.p_fifo_write_en === 1'b1) exp_acc[bus.p_grant_id] = 1'b1;
    n_checks++;
    if (bus.p_fifo_write_full && (bus.p_fifo_write_en !== 1'b0 || bus.p_req_ready !== '0)) begin
      n_fail++;
      $display("FAIL full_blocks t=%0t: write_en=%b ready=%b while full", $time,
               bus.p_fifo_write_en, bus.p_req_ready);
    end
    n_checks++;
    if (acc !== exp_acc) begin
      n_fail++;
      $display("FAIL accept_vs_write t=%0t: accepted=%b required=%b", $time, acc, exp_acc);
    end
    if (bus.p_busy === 1'b1 && prev_busy !== 1'b1) begin
      act_gid.push_back(int'(bus.p_grant_id));
      act_gb.push_back(0);
    end
    if (bus.p_fifo_write_en === 1'b1) begin
      act_sid.push_back(int'(bus.p_grant_id));
      act_sd.push_back(bus.p_fifo_write_data);
      if (act_gb.size() > 0) act_gb[act_gb.size()-1] = act_gb[act_gb.size()-1] + 1;
    end
    prev_busy = bus.p_busy;
    @(posedge write_clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    drive();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((pending() || bus.p_busy) && k < 3000) begin
      step();
      k++;
    end
    n_checks++;
    if (pending() || bus.p_busy) begin
      n_fail++;
      $display("FAIL %s_drain: traffic still pending after %0d cycles", name, k);
    end
  endtask

  // Packet-level round robin: expected write stream, grant list and counter values
  task automatic build_model();
    beat_t mq [NUM_REQ][$];
    int ptr, o, n;
    beat_t b;
    for (int i = 0; i < NUM_REQ; i++) mq[i] = rq[i];
    exp_sid.delete(); exp_sd.delete(); exp_gid.delete(); exp_gb.delete();
    ptr = 0;
    forever begin
      o = -1;
      for (int i = 0; i < NUM_REQ; i++)
        if (o < 0 && mq[(ptr + i) % NUM_REQ].size() > 0) o = (ptr + i) % NUM_REQ;
      if (o < 0) break;
      n = 0;
      while (mq[o].size() > 0 && n < MAX_BURST) begin
        b = mq[o].pop_front();
        exp_sid.push_back(o);
        exp_sd.push_back(b.data);
        stat_exp[o] = (stat_exp[o] >= SAT) ? SAT : stat_exp[o] + 1;
        n++;
        if (b.last) break;
      end
      exp_gid.push_back(o);
      exp_gb.push_back(n);
      ptr = (o + 1) % NUM_REQ;
    end
  endtask

  task automatic check_stream(input string name);
    n_checks++;
    if (act_sd.size() != exp_sd.size()) begin
      n_fail++;
      $display("FAIL %s_beats: got %0d writes, required %0d", name, act_sd.size(), exp_sd.size());
    end else begin
      foreach (exp_sd[i]) begin
        n_checks++;
        if (act_sid[i] != exp_sid[i] || act_sd[i] !== exp_sd[i]) begin
          n_fail++;
          $display("FAIL %s_write[%0d]: got id %0d data %h, required id %0d data %h",
                   name, i, act_sid[i], act_sd[i], exp_sid[i], exp_sd[i]);
        end
      end
    end
    n_checks++;
    if (act_gid.size() != exp_gid.size()) begin
      n_fail++;
      $display("FAIL %s_grants: got %0d grants, required %0d", name, act_gid.size(), exp_gid.size());
    end else begin
      foreach (exp_gid[i]) begin
        n_checks++;
        if (act_gid[i] != exp_gid[i] || act_gb[i] != exp_gb[i]) begin
          n_fail++;
          $display("FAIL %s_grant[%0d]: got id %0d beats %0d, required id %0d beats %0d",
                   name, i, act_gid[i], act_gb[i], exp_gid[i], exp_gb[i]);
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      n_checks++;
      if (int'(bus.p_stat_beats[i]) !== exp_stat(i)) begin
        n_fail++;
        $display("FAIL %s_stat[%0d]: got %0d, required %0d", name, i,
                 int'(bus.p_stat_beats[i]), exp_stat(i));
      end
    end
  endtask

  task automatic apply_reset();
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    full_plan.delete();
    clr_plan.delete();
    full_pct = 0;
    drive();
    #1 write_rst_n = 1'b0;
    repeat (2) @(posedge write_clk);
    #1 write_rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) stat_exp[i] = 0;
    prev_busy = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (bus.p_req_ready !== '0) begin n_fail++; $display("FAIL rst_ready: got %b, required 0", bus.p_req_ready); end
    n_checks++;
    if (bus.p_fifo_write_en !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %b, required 0", bus.p_fifo_write_en); end
    n_checks++;
    if (bus.p_fifo_write_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h, required 0", bus.p_fifo_write_data); end
    n_checks++;
    if (bus.p_grant_id !== '0) begin n_fail++; $display("FAIL rst_gid: got %0d, required 0", bus.p_grant_id); end
    n_checks++;
    if (bus.p_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", bus.p_busy); end
    n_checks++;
    if (bus.p_stat_beats !== '0) begin n_fail++; $display("FAIL rst_stats: got %h, required 0", bus.p_stat_beats); end
  endtask

  task automatic test_single_burst();
    logic [BITS-1:0] d [3];
    int ew [5];
    apply_reset();
    clear_trace();
    for (int k = 0; k < 3; k++) begin
      d[k] = $urandom;
      rq[0].push_back(mk(k == 2, d[k]));
    end
    build_model();
    drive();
    run_cycles(5);
    ew = '{0, 1, 1, 1, 0};
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (tr_wen[c] !== 1'(ew[c]) || tr_busy[c] !== 1'(ew[c]) || tr_gid[c] != 0) begin
        n_fail++;
        $display("FAIL single_ctrl c%0d: wen=%b busy=%b gid=%0d, required wen=busy=%0d gid=0",
                 c, tr_wen[c], tr_busy[c], tr_gid[c], ew[c]);
      end
      n_checks++;
      if (tr_data[c] !== (ew[c] != 0 ? d[(c > 0) ? c - 1 : 0] : '0)) begin
        n_fail++;
        $display("FAIL single_data c%0d: got %h", c, tr_data[c]);
      end
    end
    drain("single");
    check_stream("single");
  endtask

  task automatic test_round_robin();
    int r, g, c;
    logic [BITS-1:0] ed;
    apply_reset();
    clear_trace();
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < 8; k++) rq[i].push_back(mk(1'b0, (32'(i) << 24) | 32'(k)));
    build_model();
    drive();
    run_cycles(25);
    for (g = 0; g < 5; g++) begin
      r = g % NUM_REQ;
      n_checks++;
      if (tr_busy[5*g] !== 1'b0 || tr_wen[5*g] !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_bubble g%0d: busy=%b wen=%b, required 0 0", g, tr_busy[5*g], tr_wen[5*g]);
      end
      for (int b = 0; b < 4; b++) begin
        c  = 5*g + 1 + b;
        ed = (32'(r) << 24) | 32'((g / NUM_REQ) * 4 + b);
        n_checks++;
        if (tr_wen[c] !== 1'b1 || tr_gid[c] != r || tr_data[c] !== ed) begin
          n_fail++;
          $display("FAIL rr_beat c%0d: wen=%b gid=%0d data=%h, required 1 %0d %h",
                   c, tr_wen[c], tr_gid[c], tr_data[c], r, ed);
        end
      end
    end
    drain("rr");
    check_stream("rr");
  endtask

  task automatic test_full_stall();
    logic [BITS-1:0] d [5];
    int eb [13];
    int ei [13];
    apply_reset();
    clear_trace();
    for (int k = 0; k < 5; k++) begin
      d[k] = $urandom;
      rq[1].push_back(mk(k == 4, d[k]));
    end
    full_plan = '{0, 0, 0, 1, 1, 1, 1, 1};
    build_model();
    drive();
    run_cycles(13);
    eb = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0};
    ei = '{-1, 0, 1, -1, -1, -1, -1, -1, 2, 3, -1, 4, -1};
    for (int c = 0; c < 13; c++) begin
      n_checks++;
      if (tr_busy[c] !== 1'(eb[c]) || tr_wen[c] !== (ei[c] >= 0) ||
          (ei[c] >= 0 && (tr_data[c] !== d[(ei[c] >= 0) ? ei[c] : 0] || tr_gid[c] != 1))) begin
        n_fail++;
        $display("FAIL full_trace c%0d: busy=%b wen=%b gid=%0d data=%h, required busy=%0d beat=%0d",
                 c, tr_busy[c], tr_wen[c], tr_gid[c], tr_data[c], eb[c], ei[c]);
      end
      if (c >= 1 && c <= 9) begin
        n_checks++;
        if (tr_ready[c][1] !== ((c >= 3 && c <= 7) ? 1'b0 : 1'b1)) begin
          n_fail++;
          $display("FAIL full_ready c%0d: got %b", c, tr_ready[c][1]);
        end
      end
    end
    drain("full");
    check_stream("full");
  endtask

  task automatic test_valid_drop();
    logic [BITS-1:0] d [3];
    int eb [7];
    int ew [7];
    int eg [7];
    apply_reset();
    clear_trace();
    for (int k = 0; k < 3; k++) d[k] = $urandom;
    rq[2].push_back(mk(1'b0, d[0]));
    rq[3].push_back(mk(1'b0, d[1]));
    rq[3].push_back(mk(1'b1, d[2]));
    build_model();
    drive();
    run_cycles(7);
    eb = '{0, 1, 1, 0, 1, 1, 0};
    ew = '{0, 1, 0, 0, 1, 1, 0};
    eg = '{0, 2, 2, 2, 3, 3, 3};
    for (int c = 0; c < 7; c++) begin
      n_checks++;
      if (tr_busy[c] !== 1'(eb[c]) || tr_wen[c] !== 1'(ew[c]) || tr_gid[c] != eg[c]) begin
        n_fail++;
        $display("FAIL drop_trace c%0d: busy=%b wen=%b gid=%0d, required %0d %0d %0d",
                 c, tr_busy[c], tr_wen[c], tr_gid[c], eb[c], ew[c], eg[c]);
      end
    end
    n_checks++;
    if (tr_data[1] !== d[0] || tr_data[4] !== d[1] || tr_data[5] !== d[2]) begin
      n_fail++;
      $display("FAIL drop_data: got %h %h %h, required %h %h %h",
               tr_data[1], tr_data[4], tr_data[5], d[0], d[1], d[2]);
    end
    drain("drop");
    check_stream("drop");
  endtask

  task automatic test_reset_mid_burst();
    logic [BITS-1:0] d;
    apply_reset();
    clear_trace();
    for (int k = 0; k < 4; k++) rq[0].push_back(mk(1'b0, 32'hC0DE_0000 + 32'(k)));
    drive();
    run_cycles(2);
    n_checks++;
    if (bus.p_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy: got %b, required 1", bus.p_busy); end
    #1 write_rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.p_req_ready !== '0 || bus.p_fifo_write_en !== 1'b0 || bus.p_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: ready=%b wen=%b busy=%b, required 0 0 0",
               bus.p_req_ready, bus.p_fifo_write_en, bus.p_busy);
    end
    n_checks++;
    if (bus.p_grant_id !== '0 || bus.p_fifo_write_data !== '0) begin
      n_fail++;
      $display("FAIL midrst_gid_data: gid=%0d data=%h, required 0 0", bus.p_grant_id, bus.p_fifo_write_data);
    end
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    drive();
    @(posedge write_clk);
    #1 write_rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) stat_exp[i] = 0;
    prev_busy = 1'b0;
    n_checks++;
    if (bus.p_stat_beats !== '0) begin n_fail++; $display("FAIL midrst_stats: got %h, required 0", bus.p_stat_beats); end
    clear_trace();
    d = $urandom;
    rq[2].push_back(mk(1'b1, d));
    build_model();
    drive();
    run_cycles(3);
    n_checks++;
    if (tr_busy[0] !== 1'b0 || tr_busy[1] !== 1'b1 || tr_gid[1] != 2 || tr_wen[1] !== 1'b1 ||
        tr_data[1] !== d || tr_busy[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_regrant: busy=%b%b%b gid=%0d wen=%b data=%h, required 010 2 1 %h",
               tr_busy[0], tr_busy[1], tr_busy[2], tr_gid[1], tr_wen[1], tr_data[1], d);
    end
    check_stream("midrst");
  endtask

  task automatic test_stats();
    apply_reset();
    clear_trace();
    for (int k = 0; k < 10; k++) rq[1].push_back(mk((k % 5) == 4, $urandom));
    build_model();
    drive();
    drain("stat10");
    check_stream("stat10");
    clear_trace();
    for (int k = 0; k < 10; k++) rq[1].push_back(mk((k % 5) == 4, $urandom));
    build_model();
    drive();
    drain("stat20");
    check_stream("stat20");
    clear_trace();
    for (int k = 0; k < 3; k++) rq[1].push_back(mk(k == 2, $urandom));
    clr_plan = '{0, 1};
    drive();
    run_cycles(3);
    n_checks++;
    if (tr_wen[1] !== 1'b1 || tr_stat1[1] != (STATS_ON ? SAT : 0)) begin
      n_fail++;
      $display("FAIL stat_pre_clear: wen=%b count=%0d, required 1 %0d", tr_wen[1], tr_stat1[1],
               STATS_ON ? SAT : 0);
    end
    n_checks++;
    if (tr_stat1[2] != 0) begin
      n_fail++;
      $display("FAIL stat_clear_wins: got %0d, required 0", tr_stat1[2]);
    end
    drain("statclr");
    stat_exp[1] = 2;
    for (int i = 0; i < NUM_REQ; i++) begin
      n_checks++;
      if (int'(bus.p_stat_beats[i]) !== exp_stat(i)) begin
        n_fail++;
        $display("FAIL stat_after_clear[%0d]: got %0d, required %0d", i,
                 int'(bus.p_stat_beats[i]), exp_stat(i));
      end
    end
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 4; it++) begin
      apply_reset();
      clear_trace();
      for (int i = 0; i < NUM_REQ; i++) begin
        len = int'($urandom_range(9));
        for (int k = 0; k < len; k++) rq[i].push_back(mk($urandom_range(3) == 0, $urandom));
      end
      build_model();
      full_pct = 30;
      drive();
      drain("rand");
      check_stream("rand");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    full_pct = 0;
    prev_busy = 1'b0;
    write_rst_n = 1'b0;
    bus.p_req_valid = '0;
    bus.p_req_data = '0;
    bus.p_req_last = '0;
    bus.p_fifo_write_full = 1'b0;
    bus.p_stat_clear = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_valid_drop();
    test_reset_mid_burst();
    test_stats();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
